// File: rtl/mem_access_pkg.sv
// Shared types and default sizing for the memory access controller.
//   state_e   : controller FSM states
//   rd_src_e  : destination register of an in-flight read
//   ADDR_W / DATA_W / DATA_BASE : default address width, data width and
//               lowest writable address (everything below is program text)
package mem_access_pkg;

   localparam int unsigned ADDR_W    = 5;
   localparam int unsigned DATA_W    = 8;
   localparam int unsigned DATA_BASE = 15;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      RD_ADDR = 3'd1,
      RD_DONE = 3'd2,
      WR      = 3'd3,
      WR_DONE = 3'd4
   } state_e;

   typedef enum logic {
      SRC_FETCH = 1'b0,
      SRC_LOAD  = 1'b1
   } rd_src_e;

endpackage : mem_access_pkg

// File: rtl/mem_access_ctrl.sv
// Memory access controller: arbitrates instruction fetch, load and store
// requests onto a single data-memory port and returns results in ir / mdr.
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   fetch_req, pc               instruction fetch request and address
//   ld_req, st_req, ea, st_data load/store requests, effective address, data
//   mem_rdata                   combinational read data for mem_addr
//   mem_addr, mem_wdata         registered address / write data to memory
//   mem_write_sig               write strobe, high only in WR
//   ir, mdr                     instruction and memory data registers
//   fetch_done, ld_done, st_done one-cycle completion pulses
//   st_fault                    store to program text rejected (with st_done)
module mem_access_ctrl #(
   parameter int unsigned ADDR_W    = mem_access_pkg::ADDR_W,
   parameter int unsigned DATA_W    = mem_access_pkg::DATA_W,
   parameter int unsigned DATA_BASE = mem_access_pkg::DATA_BASE
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              fetch_req,
   input  logic [ADDR_W-1:0] pc,
   input  logic              ld_req,
   input  logic              st_req,
   input  logic [ADDR_W-1:0] ea,
   input  logic [DATA_W-1:0] st_data,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_write_sig,
   output logic [DATA_W-1:0] ir,
   output logic [DATA_W-1:0] mdr,
   output logic              fetch_done,
   output logic              ld_done,
   output logic              st_done,
   output logic              st_fault
);

   import mem_access_pkg::*;

   state_e            state_q, state_d;
   rd_src_e           src_q, src_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
   logic [DATA_W-1:0] ir_q, ir_d;
   logic [DATA_W-1:0] mdr_q, mdr_d;
   logic              write_q, write_d;
   logic              fetch_done_q, fetch_done_d;
   logic              ld_done_q, ld_done_d;
   logic              st_done_q, st_done_d;
   logic              st_fault_q, st_fault_d;
   logic              store_ok_c;

   // Unsigned full-width compare; the top address is an ordinary data word.
   assign store_ok_c = (ea >= ADDR_W'(DATA_BASE));

   // Next-state and next-output logic; pulses default low so each lasts one cycle.
   always_comb begin
      state_d      = state_q;
      src_d        = src_q;
      mem_addr_d   = mem_addr_q;
      mem_wdata_d  = mem_wdata_q;
      ir_d         = ir_q;
      mdr_d        = mdr_q;
      write_d      = 1'b0;
      fetch_done_d = 1'b0;
      ld_done_d    = 1'b0;
      st_done_d    = 1'b0;
      st_fault_d   = 1'b0;

      unique case (state_q)
         IDLE: begin
            // Fixed priority: store, then load, then fetch. Losers keep
            // their request held and are picked up on a later IDLE cycle.
            if (st_req) begin
               if (store_ok_c) begin
                  mem_addr_d  = ea;
                  mem_wdata_d = st_data;
                  write_d     = 1'b1;
                  state_d     = WR;
               end else begin
                  st_done_d  = 1'b1;
                  st_fault_d = 1'b1;
                  state_d    = WR_DONE;
               end
            end else if (ld_req) begin
               mem_addr_d = ea;
               src_d      = SRC_LOAD;
               state_d    = RD_ADDR;
            end else if (fetch_req) begin
               mem_addr_d = pc;
               src_d      = SRC_FETCH;
               state_d    = RD_ADDR;
            end
         end

         RD_ADDR: begin
            // Address has been stable for a full cycle; capture on this edge.
            if (src_q == SRC_FETCH) begin
               ir_d         = mem_rdata;
               fetch_done_d = 1'b1;
            end else begin
               mdr_d     = mem_rdata;
               ld_done_d = 1'b1;
            end
            state_d = RD_DONE;
         end

         RD_DONE: state_d = IDLE;

         WR: begin
            // Memory commits the write on this edge; strobe drops with it.
            st_done_d = 1'b1;
            state_d   = WR_DONE;
         end

         WR_DONE: state_d = IDLE;

         default: state_d = IDLE;
      endcase
   end

   // State and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         src_q        <= SRC_FETCH;
         mem_addr_q   <= '0;
         mem_wdata_q  <= '0;
         ir_q         <= '0;
         mdr_q        <= '0;
         write_q      <= 1'b0;
         fetch_done_q <= 1'b0;
         ld_done_q    <= 1'b0;
         st_done_q    <= 1'b0;
         st_fault_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         src_q        <= src_d;
         mem_addr_q   <= mem_addr_d;
         mem_wdata_q  <= mem_wdata_d;
         ir_q         <= ir_d;
         mdr_q        <= mdr_d;
         write_q      <= write_d;
         fetch_done_q <= fetch_done_d;
         ld_done_q    <= ld_done_d;
         st_done_q    <= st_done_d;
         st_fault_q   <= st_fault_d;
      end
   end

   assign mem_addr      = mem_addr_q;
   assign mem_wdata     = mem_wdata_q;
   assign mem_write_sig = write_q;
   assign ir            = ir_q;
   assign mdr           = mdr_q;
   assign fetch_done    = fetch_done_q;
   assign ld_done       = ld_done_q;
   assign st_done       = st_done_q;
   assign st_fault      = st_fault_q;

endmodule : mem_access_ctrl

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl with a behavioural data memory.
module tb_mem_access_ctrl;

   localparam int unsigned AW = 5;
   localparam int unsigned DW = 8;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          fetch_req, ld_req, st_req;
   logic [AW-1:0] pc, ea;
   logic [DW-1:0] st_data, mem_rdata;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata, ir, mdr;
   logic          mem_write_sig, fetch_done, ld_done, st_done, st_fault;

   mem_access_ctrl #(.ADDR_W(AW), .DATA_W(DW), .DATA_BASE(15)) dut (
      .clk(clk), .rst_n(rst_n),
      .fetch_req(fetch_req), .pc(pc),
      .ld_req(ld_req), .st_req(st_req), .ea(ea), .st_data(st_data),
      .mem_rdata(mem_rdata), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_write_sig(mem_write_sig), .ir(ir), .mdr(mdr),
      .fetch_done(fetch_done), .ld_done(ld_done), .st_done(st_done),
      .st_fault(st_fault)
   );

   always #5 clk = ~clk;

   // Behavioural memory: combinational read, write on rising edge.
   logic [DW-1:0] mem [32];
   assign mem_rdata = mem[mem_addr];
   always @(posedge clk) if (mem_write_sig) mem[mem_addr] <= mem_wdata;

   function automatic logic [DW-1:0] init_val(input int i);
      if (i == 3) return 8'h5A;
      return 8'(i * 7 + 1);
   endfunction

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 'h%0h expected 'h%0h at %0t", name, act, exp, $time);
      end
   endtask

   // kind: 0 fetch, 1 load, 2 store
   typedef struct {
      int            kind;
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
      logic          fault;
      logic [DW-1:0] other;
   } exp_t;

   exp_t          sb[$];
   logic [DW-1:0] ir_m, mdr_m;

   task automatic push(input int kind, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input logic f);
      exp_t e;
      e.kind = kind; e.addr = a; e.data = d; e.fault = f; e.other = '0;
      if (kind == 0) begin e.other = mdr_m; ir_m = d; end
      if (kind == 1) begin e.other = ir_m; mdr_m = d; end
      sb.push_back(e);
   endtask

   // Monitor: write tracking plus scoreboard compare on every done pulse.
   int            wr_cnt = 0;
   logic          wr_prev = 1'b0;
   logic [AW-1:0] wr_a;
   logic [DW-1:0] wr_d;

   always @(negedge clk) begin
      if (rst_n) begin
         if (mem_write_sig) begin
            check("write_pulse_single_cycle", 32'(wr_prev), 32'd0);
            wr_cnt++;
            wr_a = mem_addr;
            wr_d = mem_wdata;
         end
         wr_prev = mem_write_sig;
         if (st_fault && !st_done) check("fault_without_done", 32'd1, 32'd0);
         if (fetch_done || ld_done || st_done) begin
            int   act_kind;
            exp_t e;
            check("single_done_pulse", 32'(fetch_done) + 32'(ld_done) + 32'(st_done), 32'd1);
            act_kind = fetch_done ? 0 : (ld_done ? 1 : 2);
            if (sb.size() == 0) begin
               check("unexpected_done_kind", 32'(act_kind), 32'hFFFF);
            end else begin
               e = sb.pop_front();
               check("done_order_kind", 32'(act_kind), 32'(e.kind));
               if (e.kind == 0 && act_kind == 0) begin
                  check("fetch_ir", 32'(ir), 32'(e.data));
                  check("fetch_mdr_kept", 32'(mdr), 32'(e.other));
                  check("fetch_addr", 32'(mem_addr), 32'(e.addr));
               end else if (e.kind == 1 && act_kind == 1) begin
                  check("load_mdr", 32'(mdr), 32'(e.data));
                  check("load_ir_kept", 32'(ir), 32'(e.other));
                  check("load_addr", 32'(mem_addr), 32'(e.addr));
               end else if (e.kind == 2 && act_kind == 2) begin
                  check("store_fault", 32'(st_fault), 32'(e.fault));
                  check("store_write_count", 32'(wr_cnt), e.fault ? 32'd0 : 32'd1);
                  if (!e.fault) begin
                     check("store_write_addr", 32'(wr_a), 32'(e.addr));
                     check("store_write_data", 32'(wr_d), 32'(e.data));
                  end
                  wr_cnt = 0;
               end
            end
         end
      end
   end

   // Requester side: wait for this port's done, drop req in the same cycle.
   task automatic wait_done(input int which, output int cyc);
      bit seen = 1'b0;
      cyc = 0;
      repeat (40) begin
         if (!seen) begin
            @(negedge clk);
            cyc++;
            if (which == 0 && fetch_done) begin fetch_req = 1'b0; seen = 1'b1; end
            if (which == 1 && ld_done)    begin ld_req    = 1'b0; seen = 1'b1; end
            if (which == 2 && st_done)    begin st_req    = 1'b0; seen = 1'b1; end
         end
      end
      if (!seen) begin
         check("done_timeout", 32'(which), 32'hFFFF);
         fetch_req = 1'b0; ld_req = 1'b0; st_req = 1'b0;
      end
   endtask

   task automatic do_fetch(input logic [AW-1:0] a, output int cyc);
      @(negedge clk);
      push(0, a, mem[a], 1'b0);
      pc = a; fetch_req = 1'b1;
      wait_done(0, cyc);
   endtask

   task automatic do_load(input logic [AW-1:0] a, input logic [DW-1:0] exp, output int cyc);
      @(negedge clk);
      push(1, a, exp, 1'b0);
      ea = a; ld_req = 1'b1;
      wait_done(1, cyc);
   endtask

   task automatic do_store(input logic [AW-1:0] a, input logic [DW-1:0] d,
                           input logic f, output int cyc);
      @(negedge clk);
      push(2, a, d, f);
      ea = a; st_data = d; st_req = 1'b1;
      wait_done(2, cyc);
   endtask

   function automatic logic [31:0] all_outs();
      return 32'({mem_addr, mem_wdata, mem_write_sig, ir, mdr,
                  fetch_done, ld_done, st_done, st_fault});
   endfunction

   initial begin
      int c, c0, c1, c2;
      bit got_wr;
      for (int i = 0; i < 32; i++) mem[i] = init_val(i);
      ir_m = '0; mdr_m = '0;
      fetch_req = 0; ld_req = 0; st_req = 0;
      pc = '0; ea = '0; st_data = '0;
      rst_n = 1'b0;
      #3;
      check("reset_outputs_zero", all_outs(), 32'd0);
      #14 rst_n = 1'b1;

      // Fetch from program text
      do_fetch(5'd3, c);
      check("fetch_latency", 32'(c), 32'd2);

      // Store then load back
      do_store(5'd16, 8'hC3, 1'b0, c);
      check("store_latency", 32'(c), 32'd2);
      do_load(5'd16, 8'hC3, c);
      check("load_latency", 32'(c), 32'd2);

      // Protected store
      do_store(5'd4, 8'hFF, 1'b1, c);
      check("fault_latency", 32'(c), 32'd1);
      check("protected_mem4", 32'(mem[4]), 32'(init_val(4)));

      // Simultaneous requests: store, load, fetch order
      @(negedge clk);
      push(2, 5'd20, 8'h77, 1'b0);
      push(1, 5'd20, 8'h77, 1'b0);
      push(0, 5'd3, 8'h5A, 1'b0);
      ea = 5'd20; st_data = 8'h77; pc = 5'd3;
      st_req = 1'b1; ld_req = 1'b1; fetch_req = 1'b1;
      fork
         wait_done(2, c2);
         wait_done(1, c1);
         wait_done(0, c0);
      join

      // Boundaries
      do_store(5'd31, 8'hA1, 1'b0, c);
      do_store(5'd15, 8'hB2, 1'b0, c);
      do_store(5'd14, 8'hD4, 1'b1, c);
      do_load(5'd31, 8'hA1, c);
      do_load(5'd15, 8'hB2, c);
      check("boundary_mem14", 32'(mem[14]), 32'(init_val(14)));

      // Reset during WR aborts the store without a write or done
      @(negedge clk);
      ea = 5'd21; st_data = 8'h99; st_req = 1'b1;
      got_wr = 1'b0;
      repeat (5) begin
         if (!got_wr) begin
            @(negedge clk);
            got_wr = mem_write_sig;
         end
      end
      check("reset_test_reached_wr", 32'(got_wr), 32'd1);
      #1 rst_n = 1'b0;
      #1;
      check("reset_in_wr_strobe", 32'(mem_write_sig), 32'd0);
      check("reset_in_wr_outputs", all_outs(), 32'd0);
      st_req = 1'b0;
      wr_cnt = 0; wr_prev = 1'b0;
      ir_m = '0; mdr_m = '0;
      repeat (2) @(negedge clk);
      check("reset_in_wr_held_outputs", all_outs(), 32'd0);
      rst_n = 1'b1;
      check("reset_in_wr_mem21", 32'(mem[21]), 32'(init_val(21)));

      // First transaction after reset
      do_fetch(5'd3, c);
      check("post_reset_fetch_latency", 32'(c), 32'd2);

      repeat (3) @(negedge clk);
      check("scoreboard_drained", 32'(sb.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_mem_access_ctrl

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 Parameters SHALL be, one per line:
- ADDR_W, 5, memory address width
- DATA_W, 8, memory data width
- DATA_BASE, 15, lowest address stores may write; addresses below it hold program text
REQ-002 Ports SHALL be, one per line (name direction width meaning):
- clk  in  1  single clock; all state changes on its rising edge
- rst_n  in  1  asynchronous active-low reset
- fetch_req  in  1  instruction fetch request; held until fetch_done
- pc  in  ADDR_W  fetch address
- ld_req  in  1  load request; held until ld_done
- st_req  in  1  store request; held until st_done
- ea  in  ADDR_W  load/store effective address
- st_data  in  DATA_W  store data
- mem_rdata  in  DATA_W  read data from data memory; combinational on mem_addr
- mem_addr  out  ADDR_W  registered address to data memory
- mem_wdata  out  DATA_W  registered write data to data memory
- mem_write_sig  out  1  write strobe to data memory
- ir  out  DATA_W  instruction register
- mdr  out  DATA_W  memory data register
- fetch_done, ld_done, st_done  out  1 each  one-cycle completion pulses
- st_fault  out  1  one-cycle pulse: store rejected (ea < DATA_BASE)

Function
REQ-003 FSM states SHALL be IDLE, RD_ADDR, RD_DONE, WR, WR_DONE.
REQ-004 In IDLE, one pending request SHALL be accepted per cycle; priority st_req > ld_req > fetch_req; unaccepted requests stay pending, never dropped.
REQ-005 Read accept (ld or fetch): mem_addr <= ea or pc, record source; IDLE -> RD_ADDR.
REQ-006 RD_ADDR: mem_addr held stable a full cycle; at its closing edge mem_rdata SHALL be captured into ir (fetch) or mdr (load), other register unchanged; -> RD_DONE.
REQ-007 RD_DONE: fetch_done or ld_done = 1 for exactly this cycle; -> IDLE. Read latency: done pulse 2 cycles after acceptance edge.
REQ-008 Store accept with ea >= DATA_BASE: mem_addr <= ea, mem_wdata <= st_data, mem_write_sig <= 1; IDLE -> WR.
REQ-009 WR: mem_write_sig = 1 for exactly this cycle (memory writes on its closing edge); -> WR_DONE with mem_write_sig <= 0.
REQ-010 Store accept with ea < DATA_BASE: no write strobe; IDLE -> WR_DONE; st_fault = 1 together with st_done.
REQ-011 WR_DONE: st_done = 1 for one cycle; -> IDLE.
REQ-012 Requesters SHALL deassert req in the cycle done is seen; a req still high in IDLE after that is a new transaction.
REQ-013 Requests changing while not in IDLE SHALL be ignored until IDLE.
REQ-014 mem_write_sig SHALL never be high outside WR; at most one write per st_req transaction.
REQ-015 Address compare unsigned, full ADDR_W; ea = 31 is legal (no wrap).

Reset
REQ-016 rst_n low SHALL immediately force state IDLE, mem_addr, mem_wdata, ir, mdr to 0 and all strobes/pulses to 0, independent of clk.
REQ-017 Reset mid-transaction SHALL abort it with no done pulse; reset during WR SHALL drop mem_write_sig before the next edge.
REQ-018 After rst_n rises, first acceptance SHALL occur on the first rising edge with a request pending.

Structure
REQ-019 Package mem_access_pkg SHALL hold the state enum, the read-source typedef (SRC_FETCH, SRC_LOAD), and default ADDR_W, DATA_W, DATA_BASE.
REQ-020 Single flat module; no sub-module required; instantiated beside the data memory with mem_* ports wired directly.

Verification
REQ-021 Fetch: mem[3]=8'h5A, fetch_req=1, pc=3 -> mem_addr=3, fetch_done 2 cycles after acceptance, ir=8'h5A, mdr unchanged.
REQ-022 Store then load: st ea=16 data=8'hC3 -> one mem_write_sig cycle at addr 16, st_done; then ld ea=16 -> ld_done, mdr=8'hC3.
REQ-023 Protected store: st ea=4 data=8'hFF -> st_done and st_fault same cycle, mem_write_sig never high, mem[4] unchanged.
REQ-024 Simultaneous: fetch_req, ld_req, st_req rise together -> order store, load, fetch; three done pulses, none lost.
REQ-025 Reset in WR: pulse rst_n low during WR -> mem_write_sig falls without clk edge, no st_done, all outputs 0.
REQ-026 Boundary: store ea=31 and ea=15 both write; ea=14 faults.
